// File: rtl/iq_pkg.sv
// Shared definitions for the IQ weight estimator slice.
// Holds the controller state encoding, the sample/weight width and the
// weight range limits, plus a clamp helper used by the saturating build.
package iq_pkg;

    localparam int unsigned SAMPLE_W = 4;
    localparam int signed   W_MIN    = -8;
    localparam int signed   W_MAX    = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Clamp a full-width weight candidate into the representable range.
    function automatic logic signed [SAMPLE_W-1:0] clamp_w(input int v);
        if (v > W_MAX) begin
            return SAMPLE_W'(W_MAX);
        end
        if (v < W_MIN) begin
            return SAMPLE_W'(W_MIN);
        end
        return SAMPLE_W'(v);
    endfunction

endpackage

// File: rtl/iq_weight_est_if.sv
// Sample/weight bus between the compensator side and iq_weight_est.
//   en, clr, in_valid, Iy, Qy : driven by the master (compensator / bench)
//   Wr, Wj, w_valid, busy     : driven by the slave (estimator)
interface iq_weight_est_if;
    import iq_pkg::*;

    logic                       en;
    logic                       clr;
    logic                       in_valid;
    logic signed [SAMPLE_W-1:0] Iy;
    logic signed [SAMPLE_W-1:0] Qy;
    logic signed [SAMPLE_W-1:0] Wr;
    logic signed [SAMPLE_W-1:0] Wj;
    logic                       w_valid;
    logic                       busy;

    modport master (
        output en, clr, in_valid, Iy, Qy,
        input  Wr, Wj, w_valid, busy
    );

    modport slave (
        input  en, clr, in_valid, Iy, Qy,
        output Wr, Wj, w_valid, busy
    );

endinterface

// File: rtl/iq_mac.sv
// Product/accumulate datapath for the IQ weight estimator.
// Forms Iy*Iy - Qy*Qy and Iy*Qy at full precision and sums them into one
// accumulator pair.
//   clk, RESET       : clock, async active-high reset
//   clr_i            : clear both accumulators (wins over en_i)
//   en_i             : add the current products
//   iy_i, qy_i       : signed samples
//   acc_r_o, acc_j_o : registered accumulator values
module iq_mac
    import iq_pkg::*;
#(
    parameter int unsigned ACC_W = 15
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic                       clr_i,
    input  logic                       en_i,
    input  logic signed [SAMPLE_W-1:0] iy_i,
    input  logic signed [SAMPLE_W-1:0] qy_i,
    output logic signed [ACC_W-1:0]    acc_r_o,
    output logic signed [ACC_W-1:0]    acc_j_o
);

    localparam int unsigned PROD_W = 2 * SAMPLE_W + 1;

    logic signed [PROD_W-1:0] iy_x, qy_x, term_r, term_j;
    logic signed [ACC_W-1:0]  acc_r_q, acc_r_d, acc_j_q, acc_j_d;

    always_comb begin
        iy_x    = PROD_W'(iy_i);
        qy_x    = PROD_W'(qy_i);
        term_r  = iy_x * iy_x - qy_x * qy_x;
        term_j  = iy_x * qy_x;
        acc_r_d = acc_r_q;
        acc_j_d = acc_j_q;
        if (clr_i) begin
            acc_r_d = '0;
            acc_j_d = '0;
        end else if (en_i) begin
            acc_r_d = acc_r_q + ACC_W'(term_r);
            acc_j_d = acc_j_q + ACC_W'(term_j);
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            acc_r_q <= '0;
            acc_j_q <= '0;
        end else begin
            acc_r_q <= acc_r_d;
            acc_j_q <= acc_j_d;
        end
    end

    assign acc_r_o = acc_r_q;
    assign acc_j_o = acc_j_q;

endmodule

// File: rtl/iq_weight_est.sv
// Block-LMS style IQ imbalance weight estimator.
// Accumulates 2^LOG2_N valid samples of (Iy^2 - Qy^2, Iy*Qy), then steps the
// complex weight (Wr, Wj) against the scaled block sums.
//   clk, RESET : clock, async active-high reset
//   bus        : iq_weight_est_if.slave (en, clr, in_valid, Iy, Qy in;
//                Wr, Wj, w_valid, busy out)
// Build option: define IQ_WEIGHT_EST_SAT_EN to clamp weights to [-8, 7];
// otherwise weight updates wrap modulo 16.
module iq_weight_est
    import iq_pkg::*;
#(
    parameter int unsigned LOG2_N   = 6,
    parameter int unsigned MU_SHIFT = 4
) (
    input logic             clk,
    input logic             RESET,
    iq_weight_est_if.slave  bus
);

    localparam int unsigned ACC_W = 2 * SAMPLE_W + 1 + LOG2_N;
    localparam int unsigned SHIFT = LOG2_N + MU_SHIFT;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    state_t                     state_q, state_d;
    logic [LOG2_N-1:0]          cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] wr_q, wr_d, wj_q, wj_d;
    logic                       w_valid_q, w_valid_d;
    logic                       acc_en, acc_clr;
    logic signed [ACC_W-1:0]    acc_r, acc_j, step_r, step_j;
    int                         wr_full, wj_full;

    iq_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .RESET   (RESET),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .iy_i    (bus.Iy),
        .qy_i    (bus.Qy),
        .acc_r_o (acc_r),
        .acc_j_o (acc_j)
    );

    assign step_r = acc_r >>> SHIFT;
    assign step_j = acc_j >>> SHIFT;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        wj_d      = wj_q;
        w_valid_d = 1'b0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        wr_full   = int'(wr_q) - int'(step_r);
        wj_full   = int'(wj_q) - int'(step_j);

        unique case (state_q)
            IDLE: begin
                // Sums are held at zero while idle so every block starts clean.
                acc_clr = 1'b1;
                cnt_d   = '0;
                if (bus.en) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE: begin
                acc_clr   = 1'b1;
                cnt_d     = '0;
                w_valid_d = 1'b1;
`ifdef IQ_WEIGHT_EST_SAT_EN
                wr_d = clamp_w(wr_full);
                wj_d = clamp_w(wj_full);
`else
                wr_d = SAMPLE_W'(wr_full);
                wj_d = SAMPLE_W'(wj_full);
`endif
                state_d = bus.en ? ACCUM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides any weight update but leaves the pulse and FSM alone.
        if (bus.clr) begin
            wr_d = '0;
            wj_d = '0;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= '0;
            wj_q      <= '0;
            w_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            wj_q      <= wj_d;
            w_valid_q <= w_valid_d;
        end
    end

    assign bus.Wr      = wr_q;
    assign bus.Wj      = wj_q;
    assign bus.w_valid = w_valid_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_iq_weight_est.sv
// Self-checking bench for iq_weight_est (LOG2_N=2, MU_SHIFT=0).
// Expected weights come from block sums computed with plain integer
// arithmetic and floor division; the overflow rule follows the
// IQ_WEIGHT_EST_SAT_EN build option.
module tb_iq_weight_est;

    localparam int LOG2_N   = 2;
    localparam int MU_SHIFT = 0;
    localparam int N        = 1 << LOG2_N;

    logic clk = 1'b0;
    logic RESET;

    iq_weight_est_if bus ();

    iq_weight_est #(
        .LOG2_N   (LOG2_N),
        .MU_SHIFT (MU_SHIFT)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_wr = 0;
    int exp_wj = 0;
    int s_i[N];
    int s_q[N];
    bit in_accum = 1'b0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int fix_w(input int v);
`ifdef IQ_WEIGHT_EST_SAT_EN
        if (v > 7) return 7;
        if (v < -8) return -8;
        return v;
`else
        int m;
        m = v % 16;
        if (m < 0) m += 16;
        if (m > 7) m -= 16;
        return m;
`endif
    endfunction

    task automatic set_const(input int iv, input int qv);
        for (int k = 0; k < N; k++) begin
            s_i[k] = iv;
            s_q[k] = qv;
        end
    endtask

    // One full estimation block: N accepted samples with `gap` empty cycles
    // before each, then the UPDATE cycle and the cycle after it.
    task automatic run_block(input int gap, input bit clr_upd, input bit keep_en);
        int sum_r = 0;
        int sum_j = 0;
        int div = 1 << (LOG2_N + MU_SHIFT);
        bus.en = 1'b1;
        if (!in_accum) tick();
        for (int k = 0; k < N; k++) begin
            repeat (gap) begin
                bus.in_valid = 1'b0;
                bus.Iy = 4'($urandom);
                bus.Qy = 4'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.Iy = 4'(s_i[k]);
            bus.Qy = 4'(s_q[k]);
            sum_r += s_i[k] * s_i[k] - s_q[k] * s_q[k];
            sum_j += s_i[k] * s_q[k];
            tick();
            if (k == 0) check("busy_accum", bus.busy, 1);
        end
        check("busy_update", bus.busy, 1);
        check("wvalid_before_update", bus.w_valid, 0);
        // A sample offered during UPDATE must be ignored.
        bus.in_valid = 1'b1;
        bus.Iy = 4'($urandom);
        bus.Qy = 4'($urandom);
        bus.en = keep_en;
        bus.clr = clr_upd;
        tick();
        bus.clr = 1'b0;
        bus.in_valid = 1'b0;
        if (clr_upd) begin
            exp_wr = 0;
            exp_wj = 0;
        end else begin
            exp_wr = fix_w(exp_wr - floor_div(sum_r, div));
            exp_wj = fix_w(exp_wj - floor_div(sum_j, div));
        end
        check("wr_update", bus.Wr, exp_wr);
        check("wj_update", bus.Wj, exp_wj);
        check("wvalid_pulse", bus.w_valid, 1);
        check("busy_after_update", bus.busy, 32'(keep_en));
        tick();
        check("wvalid_single", bus.w_valid, 0);
        check("wr_hold", bus.Wr, exp_wr);
        in_accum = keep_en;
    endtask

    initial begin
        RESET = 1'b1;
        bus.en = 1'b0;
        bus.clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.Iy = '0;
        bus.Qy = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr", bus.Wr, 0);
        check("rst_wj", bus.Wj, 0);
        check("rst_wvalid", bus.w_valid, 0);
        check("rst_busy", bus.busy, 0);
        RESET = 1'b0;
        tick();
        check("idle_busy", bus.busy, 0);

        // Samples while idle are dropped and do not start anything.
        bus.in_valid = 1'b1;
        bus.Iy = 4'sd7;
        bus.Qy = 4'sd2;
        tick();
        bus.in_valid = 1'b0;
        check("idle_discard_busy", bus.busy, 0);
        check("idle_discard_wvalid", bus.w_valid, 0);

        // Two back-to-back blocks of Iy=3, Qy=1.
        set_const(3, 1);
        run_block(0, 1'b0, 1'b1);
        check("blk1_wr_const", bus.Wr, -8);
        check("blk1_wj_const", bus.Wj, -3);
        run_block(0, 1'b0, 1'b0);
`ifdef IQ_WEIGHT_EST_SAT_EN
        check("blk2_wr_const", bus.Wr, -8);
`else
        check("blk2_wr_const", bus.Wr, 0);
`endif
        check("blk2_wj_const", bus.Wj, -6);

        // Abort after two samples.
        bus.en = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.Iy = 4'sd3;
            bus.Qy = 4'sd1;
            tick();
        end
        bus.en = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("abort_busy", bus.busy, 0);
        check("abort_wvalid", bus.w_valid, 0);
        check("abort_wr", bus.Wr, exp_wr);
        check("abort_wj", bus.Wj, exp_wj);
        tick();
        check("abort_wvalid_late", bus.w_valid, 0);
        in_accum = 1'b0;

        // Clear coincident with UPDATE; then a fresh block from zero.
        run_block(0, 1'b1, 1'b0);
        check("clr_upd_wr", bus.Wr, 0);
        run_block(0, 1'b0, 1'b0);
        check("fresh_wr_const", bus.Wr, -8);
        check("fresh_wj_const", bus.Wj, -3);

        // Clear while idle.
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        exp_wr = 0;
        exp_wj = 0;
        check("clr_idle_wr", bus.Wr, 0);
        check("clr_idle_wj", bus.Wj, 0);
        check("clr_idle_busy", bus.busy, 0);

        // Sparse valid, extreme negative samples.
        set_const(-8, -8);
        run_block(2, 1'b0, 1'b0);
        check("neg_wr_const", bus.Wr, 0);
`ifdef IQ_WEIGHT_EST_SAT_EN
        check("neg_wj_const", bus.Wj, -8);
`else
        check("neg_wj_const", bus.Wj, 0);
`endif

        // Make weights non-zero, then reset in the middle of a block.
        set_const(3, 1);
        run_block(0, 1'b0, 1'b0);
        bus.en = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            tick();
        end
        #3;
        RESET = 1'b1;
        #1;
        exp_wr = 0;
        exp_wj = 0;
        check("midrst_wr", bus.Wr, 0);
        check("midrst_wj", bus.Wj, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_wvalid", bus.w_valid, 0);
        #1;
        RESET = 1'b0;
        bus.en = 1'b0;
        bus.in_valid = 1'b0;
        in_accum = 1'b0;
        tick();
        run_block(0, 1'b0, 1'b0);
        check("postrst_wr_const", bus.Wr, -8);
        check("postrst_wj_const", bus.Wj, -3);

        // Randomized blocks.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < N; k++) begin
                s_i[k] = int'($urandom_range(0, 15)) - 8;
                s_q[k] = int'($urandom_range(0, 15)) - 8;
            end
            run_block(int'($urandom_range(0, 2)), ($urandom_range(0, 5) == 0),
                      (r < 9) ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_weight_est.md
IQ_WEIGHT_EST -- requirements
Module: iq_weight_est

Interface
REQ-001 Parameter LOG2_N, default 6, log2 of samples per estimation block (N = 2^LOG2_N, legal 1..10).
REQ-002 Parameter MU_SHIFT, default 4, extra right-shift applied to block sums (step size).
REQ-003 The block SHALL have one clock, clk; reset RESET is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 RESET  input  1  async active-high reset.
REQ-006 en  input  1  adaptation enable; level-sensitive.
REQ-007 clr  input  1  synchronous weight clear.
REQ-008 in_valid  input  1  Iy/Qy carry a sample this cycle.
REQ-009 Iy  input  4  signed compensated I sample from the compensator.
REQ-010 Qy  input  4  signed compensated Q sample from the compensator.
REQ-011 Wr  output  4  signed real weight, registered, fed back to the compensator.
REQ-012 Wj  output  4  signed imaginary weight, registered.
REQ-013 w_valid  output  1  one-cycle pulse when Wr/Wj update.
REQ-014 busy  output  1  high in states ACCUM and UPDATE.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, UPDATE.
REQ-016 IDLE->ACCUM when en=1; accumulators accR, accJ and sample counter cnt cleared on entry.
REQ-017 In ACCUM, each cycle with in_valid=1: accR += Iy*Iy - Qy*Qy; accJ += Iy*Qy; cnt += 1.
REQ-018 Products SHALL be full-precision signed (9-bit term); accumulators SHALL be 9+LOG2_N bits signed and SHALL never overflow.
REQ-019 ACCUM->UPDATE on the cycle the N-th valid sample is accumulated (cnt = N-1 with in_valid).
REQ-020 In UPDATE (exactly one cycle): stepR = accR >>> (LOG2_N+MU_SHIFT), stepJ likewise (arithmetic shift, floor).
REQ-021 In UPDATE: Wr <= Wr - stepR, Wj <= Wj - stepJ, width rule per REQ-033; w_valid=1 that cycle only.
REQ-022 UPDATE->ACCUM (accumulators and cnt cleared) if en=1, else UPDATE->IDLE.
REQ-023 in_valid samples during UPDATE or IDLE SHALL be discarded.
REQ-024 en=0 during ACCUM SHALL abort: return to IDLE next cycle, partial sums discarded, Wr/Wj unchanged, no w_valid.
REQ-025 clr=1 SHALL set Wr=Wj=0 next cycle in any state; FSM state and accumulators unaffected.
REQ-026 clr coincident with UPDATE: clr wins (Wr=Wj=0), w_valid still pulses.
REQ-027 Latency: weights visible one clk after the N-th accepted sample's edge plus one (UPDATE register stage).

Reset
REQ-028 RESET=1 SHALL asynchronously force state=IDLE, Wr=0, Wj=0, w_valid=0, busy=0, accR=accJ=0, cnt=0.
REQ-029 RESET asserted mid-block SHALL discard the block; after release the FSM restarts from IDLE.
REQ-030 Release of RESET SHALL be taken synchronously; first transition possible on the following rising edge.

Configuration
REQ-031 Macro IQ_WEIGHT_EST_SAT_EN selects weight overflow handling.
REQ-032 With IQ_WEIGHT_EST_SAT_EN defined: Wr/Wj updates computed at full width and clamped to [-8, 7].
REQ-033 Without it: updates wrap modulo 16 (two's-complement truncation to 4 bits).

Structure
REQ-034 Shared package iq_pkg SHALL hold the state enum (IDLE/ACCUM/UPDATE), sample width constant 4, and weight min/max constants.
REQ-035 One sub-module iq_mac SHALL compute the two products and hold one accumulator pair (clear, enable inputs).
REQ-036 FSM, counter, and weight update SHALL live in iq_weight_est.

Verification (LOG2_N=2, MU_SHIFT=0 unless stated)
REQ-037 Reset then en=1, 4 valid samples Iy=3, Qy=1 -> w_valid pulse, Wr=-8, Wj=-3.
REQ-038 Same stimulus for a second block -> with SAT_EN Wr=-8, Wj=-6; without SAT_EN Wr=0, Wj=-6.
REQ-039 en=1, 2 valid samples, then en=0 -> IDLE next cycle, no w_valid, Wr/Wj unchanged.
REQ-040 4 samples with in_valid gaps (valid every 3rd cycle), Iy=-8, Qy=-8 -> accR=0, accJ=256, Wr=0, Wj clamps to -8 (SAT_EN).
REQ-041 clr asserted on UPDATE cycle of REQ-037 stimulus -> Wr=Wj=0, w_valid=1.
REQ-042 RESET pulsed mid-ACCUM (between clock edges) -> outputs zero immediately, busy=0, next en=1 block yields REQ-037 result.
